// File: rtl/dma_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dma_frame_scheduler
// Description : Launches one SDRAM->distributed-RAM DMA per accepted frame tick,
//               manages double-buffer swaps, overrun counting and DMA timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_frame_scheduler #(
  parameter int ADDR_W         = 29,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              frame_tick,
  input  logic              swap_req,
  input  logic [ADDR_W-1:0] buf0_address,
  input  logic [ADDR_W-1:0] buf1_address,
  input  logic [31:0]       frame_words,
  input  logic              error_clear,
  input  logic              dma_idle,
  output logic              dma_start,
  output logic [ADDR_W-1:0] dma_begin_address,
  output logic [31:0]       dma_size,
  output logic              dist_bank,
  output logic              active_buf,
  output logic              swap_ack,
  output logic [15:0]       frame_count,
  output logic [7:0]        overrun_count,
  output logic              timeout_error
);

  localparam int                 C_TIMER_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_TIMER_W-1:0] C_TIMEOUT_LIMIT = C_TIMER_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  state_t               r_state;
  logic [1:0]           r_rst_sync;
  logic                 w_rst_n;
  logic                 r_dma_start;
  logic [ADDR_W-1:0]    r_dma_begin_address;
  logic [31:0]          r_dma_size;
  logic                 r_dist_bank;
  logic                 r_active_buf;
  logic                 r_swap_pending;
  logic                 r_swap_ack;
  logic [15:0]          r_frame_count;
  logic [7:0]           r_overrun_count;
  logic                 r_timeout_error;
  logic [C_TIMER_W-1:0] r_timer;

  logic                 w_tick_accept;
  logic                 w_swap_now;
  logic                 w_next_buf;
  logic                 w_in_xfer;
  logic                 w_timing;
  logic                 w_overrun;
  logic                 w_done;
  logic                 w_timeout;
  logic [C_TIMER_W-1:0] w_timer_next;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_tick_accept = (r_state == ST_WAIT_TICK) && enable && frame_tick &&
                         (frame_words != 32'd0);
  assign w_swap_now    = w_tick_accept && (r_swap_pending || swap_req);
  assign w_next_buf    = r_active_buf ^ w_swap_now;
  assign w_timing      = (r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE);
  assign w_in_xfer     = w_timing || (r_state == ST_LAUNCH);
  assign w_overrun     = w_in_xfer && enable && frame_tick;
  assign w_done        = (r_state == ST_WAIT_DONE) && dma_idle;
  assign w_timer_next  = r_timer + 1'b1;
  // A completion seen in the final cycle wins over the timeout.
  assign w_timeout     = w_timing && !w_done && (w_timer_next >= C_TIMEOUT_LIMIT);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state             <= ST_IDLE;
      r_dma_start         <= 1'b0;
      r_dma_begin_address <= '0;
      r_dma_size          <= 32'd0;
      r_dist_bank         <= 1'b0;
      r_active_buf        <= 1'b0;
      r_swap_pending      <= 1'b0;
      r_swap_ack          <= 1'b0;
      r_frame_count       <= 16'd0;
      r_overrun_count     <= 8'd0;
      r_timeout_error     <= 1'b0;
      r_timer             <= '0;
    end else begin
      r_dma_start <= 1'b0;
      r_swap_ack  <= 1'b0;

      if (w_swap_now)    r_swap_pending <= 1'b0;
      else if (swap_req) r_swap_pending <= 1'b1;

      if (w_overrun && (r_overrun_count != 8'hFF))
        r_overrun_count <= r_overrun_count + 8'd1;

      if (w_timeout)        r_timeout_error <= 1'b1;
      else if (error_clear) r_timeout_error <= 1'b0;

      if (w_tick_accept) r_timer <= '0;
      else if (w_timing) r_timer <= w_timer_next;

      case (r_state)
        ST_IDLE: begin
          if (enable) r_state <= ST_WAIT_TICK;
        end
        ST_WAIT_TICK: begin
          if (!enable) begin
            r_state <= ST_IDLE;
          end else if (w_tick_accept) begin
            r_dma_begin_address <= w_next_buf ? buf1_address : buf0_address;
            r_dma_size          <= frame_words;
            r_active_buf        <= w_next_buf;
            r_swap_ack          <= w_swap_now;
            r_dma_start         <= 1'b1;
            r_state             <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (w_timeout)     r_state <= enable ? ST_WAIT_TICK : ST_IDLE;
          else if (!dma_idle) r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (w_done) begin
            r_dist_bank   <= ~r_dist_bank;
            r_frame_count <= r_frame_count + 16'd1;
            r_state       <= enable ? ST_WAIT_TICK : ST_IDLE;
          end else if (w_timeout) begin
            r_state <= enable ? ST_WAIT_TICK : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dma_start         = r_dma_start;
  assign dma_begin_address = r_dma_begin_address;
  assign dma_size          = r_dma_size;
  assign dist_bank         = r_dist_bank;
  assign active_buf        = r_active_buf;
  assign swap_ack          = r_swap_ack;
  assign frame_count       = r_frame_count;
  assign overrun_count     = r_overrun_count;
  assign timeout_error     = r_timeout_error;

endmodule
`default_nettype wire

// File: doc/dma_frame_scheduler.md
DMA_FRAME_SCHEDULER -- requirements
Module: dma_frame_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 29, SDRAM word-address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, max clk cycles from dma_start to transfer completion.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  level; 1 = schedule frame refreshes.
REQ-006 SHALL have port frame_tick  input  1  one-cycle pulse from matrix scanner at frame boundary.
REQ-007 SHALL have port swap_req  input  1  one-cycle pulse from HPS: back buffer fully written.
REQ-008 SHALL have port buf0_address, buf1_address  input  ADDR_W  SDRAM base addresses of the two frame buffers.
REQ-009 SHALL have port frame_words  input  32  64-bit words per frame.
REQ-010 SHALL have port error_clear  input  1  pulse; clears timeout_error.
REQ-011 SHALL have port dma_idle  input  1  1 while the SDRAM DMA engine is in its idle state.
REQ-012 SHALL have port dma_start  output  1  one-cycle start pulse to the DMA.
REQ-013 SHALL have port dma_begin_address  output  ADDR_W  DMA start address.
REQ-014 SHALL have port dma_size  output  32  DMA transfer length in words.
REQ-015 SHALL have port dist_bank  output  1  distributed-RAM page the scanner displays; DMA writes the other page.
REQ-016 SHALL have port active_buf  output  1  SDRAM buffer currently sourced (0 = buf0).
REQ-017 SHALL have port swap_ack  output  1  one-cycle pulse when a pending swap takes effect.
REQ-018 SHALL have port frame_count  output  16  completed transfers, wraps at 65535 -> 0.
REQ-019 SHALL have port overrun_count  output  8  dropped frame_ticks, saturates at 255.
REQ-020 SHALL have port timeout_error  output  1  sticky timeout flag.

Function
REQ-021 SHALL implement states IDLE, WAIT_TICK, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-022 IDLE -> WAIT_TICK when enable=1; WAIT_TICK -> IDLE when enable=0.
REQ-023 WAIT_TICK on frame_tick with frame_words!=0: latch dma_begin_address (buf1_address if active_buf after swap resolution, else buf0_address) and dma_size=frame_words; -> LAUNCH.
REQ-024 WAIT_TICK on frame_tick with frame_words==0: no launch, no counters change, stay WAIT_TICK.
REQ-025 swap_req SHALL set swap_pending; at the accepted frame_tick, if pending (including swap_req in the same cycle), active_buf toggles, pending clears, swap_ack pulses that cycle.
REQ-026 LAUNCH SHALL assert dma_start for exactly one cycle, then -> WAIT_BUSY; latency frame_tick to dma_start = 1 cycle.
REQ-027 WAIT_BUSY -> WAIT_DONE when dma_idle=0; WAIT_DONE on dma_idle=1: dist_bank toggles, frame_count increments, -> WAIT_TICK (or IDLE if enable=0).
REQ-028 Timeout counter SHALL clear at dma_start and count in WAIT_BUSY/WAIT_DONE; reaching TIMEOUT_CYCLES sets timeout_error, no bank toggle, no frame_count change, -> WAIT_TICK/IDLE per enable.
REQ-029 dma_begin_address and dma_size SHALL be held stable from LAUNCH until leaving WAIT_DONE.
REQ-030 frame_tick in LAUNCH/WAIT_BUSY/WAIT_DONE SHALL be dropped and increment overrun_count (saturating); frame_tick while enable=0 is ignored, not counted.
REQ-031 enable deassert during a transfer SHALL let the transfer complete or time out, then -> IDLE.
REQ-032 error_clear clears timeout_error; timeout set in the same cycle takes priority.
REQ-033 swap_req during a transfer SHALL only set pending; applied at the next accepted tick.

Reset
REQ-034 rst=0 SHALL asynchronously force state IDLE, dma_start=0, dma_begin_address=0, dma_size=0, dist_bank=0, active_buf=0, swap_pending=0, swap_ack=0, frame_count=0, overrun_count=0, timeout_error=0, timeout counter=0.
REQ-035 Reset asserted mid-transfer SHALL abort with no completion effects; release is synchronised to clk.

Verification
REQ-036 enable=1, frame_words=256, buf0=0x1000, tick -> dma_start 1 cycle later, address 0x1000, size 256; dma_idle 0 then 1 -> dist_bank=1, frame_count=1.
REQ-037 swap_req then tick, buf1=0x2000 -> swap_ack and active_buf=1 at tick, dma_begin_address=0x2000.
REQ-038 Three ticks during one transfer -> overrun_count=3, single dma_start; 300 dropped ticks -> overrun_count=255.
REQ-039 dma_idle held 1 after start, TIMEOUT_CYCLES=16 -> timeout_error=1 at cycle 16, dist_bank unchanged; error_clear -> 0.
REQ-040 rst=0 during WAIT_DONE -> all outputs to reset values immediately; frame_words=0 tick -> no dma_start.
